// File: rtl/div_sequencer.sv
// div_sequencer: control FSM for the serial signed divider bitslice array.
// Walks LOAD -> WIDTH restoring iterations -> sign fix-up -> DONE and emits
// the per-cycle strobes that fan out to every bitslice.
module div_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic Clock,
  input  logic nReset,
  input  logic Test,
  input  logic Start,
  input  logic Op1_Sign,
  input  logic Op2_Sign,
  input  logic Op2_Zero,
  input  logic ACC_Cout,
  output logic LOAD_DIVH,
  output logic LOAD_DIVL,
  output logic INV_OP1,
  output logic OP1_INV_Cin,
  output logic INV_OP2,
  output logic OP2_INV_Cin,
  output logic ACC_LOAD,
  output logic DIVL_P,
  output logic RESULT_P,
  output logic LOAD_QUOT,
  output logic LOAD_REM,
  output logic INV_RESULT,
  output logic RESULT_INV_Cin,
  output logic INV_REM,
  output logic Busy,
  output logic Done,
  output logic Div_Zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_div_zero;
  logic             w_last_iter;

  assign w_last_iter = (r_cnt == LAST_ITER);
  assign Div_Zero    = r_div_zero;

  // State register: synchronous reset, frozen while scan mode is active.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      r_state <= S_IDLE;
    end else if (!Test) begin
      r_state <= w_state_nxt;
    end
  end

  // Iteration counter and sign/zero flags captured during LOAD.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      r_cnt      <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (!Test) begin
      case (r_state)
        S_LOAD: begin
          r_cnt      <= '0;
          r_q_neg    <= Op1_Sign ^ Op2_Sign;
          r_r_neg    <= Op1_Sign;
          r_div_zero <= Op2_Zero;
        end
        S_ITER:  r_cnt <= r_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Next-state decode and Moore strobes; scan mode masks the load/shift strobes.
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    LOAD_DIVH      = 1'b0;
    LOAD_DIVL      = 1'b0;
    INV_OP1        = 1'b0;
    OP1_INV_Cin    = 1'b0;
    INV_OP2        = 1'b0;
    OP2_INV_Cin    = 1'b0;
    ACC_LOAD       = 1'b0;
    DIVL_P         = 1'b0;
    RESULT_P       = 1'b0;
    LOAD_QUOT      = 1'b0;
    LOAD_REM       = 1'b0;
    INV_RESULT     = 1'b0;
    RESULT_INV_Cin = 1'b0;
    INV_REM        = 1'b0;
    Busy           = 1'b0;
    Done           = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (Start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        Busy        = 1'b1;
        LOAD_DIVH   = 1'b1;
        LOAD_DIVL   = 1'b1;
        INV_OP1     = Op1_Sign;
        OP1_INV_Cin = Op1_Sign;
        INV_OP2     = Op2_Sign;
        OP2_INV_Cin = Op2_Sign;
        w_state_nxt = Op2_Zero ? S_DONE : S_ITER;
      end
      S_ITER: begin
        Busy     = 1'b1;
        DIVL_P   = 1'b1;
        // Restoring division: commit the trial subtract only when it fits.
        RESULT_P = ACC_Cout;
        ACC_LOAD = ACC_Cout;
        if (w_last_iter) w_state_nxt = S_FIX;
      end
      S_FIX: begin
        Busy           = 1'b1;
        LOAD_QUOT      = 1'b1;
        LOAD_REM       = 1'b1;
        INV_RESULT     = r_q_neg;
        RESULT_INV_Cin = r_q_neg;
        INV_REM        = r_r_neg;
        w_state_nxt    = S_DONE;
      end
      S_DONE: begin
        Busy        = 1'b1;
        Done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Scan mode must not disturb the array: suppress every load and shift.
    if (Test) begin
      LOAD_DIVH = 1'b0;
      LOAD_DIVL = 1'b0;
      ACC_LOAD  = 1'b0;
      DIVL_P    = 1'b0;
      RESULT_P  = 1'b0;
      LOAD_QUOT = 1'b0;
      LOAD_REM  = 1'b0;
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer (WIDTH=8): checks every output every cycle
// against hand-built strobe masks.
module tb_div_sequencer;

  logic Clock = 1'b0;
  logic nReset, Test, Start, Op1_Sign, Op2_Sign, Op2_Zero, ACC_Cout;
  logic LOAD_DIVH, LOAD_DIVL, INV_OP1, OP1_INV_Cin, INV_OP2, OP2_INV_Cin;
  logic ACC_LOAD, DIVL_P, RESULT_P, LOAD_QUOT, LOAD_REM;
  logic INV_RESULT, RESULT_INV_Cin, INV_REM, Busy, Done, Div_Zero;

  int total = 0;
  int bad   = 0;

  localparam logic [16:0] M_LDH = 17'h10000, M_LDL = 17'h08000;
  localparam logic [16:0] M_IO1 = 17'h04000, M_O1C = 17'h02000;
  localparam logic [16:0] M_IO2 = 17'h01000, M_O2C = 17'h00800;
  localparam logic [16:0] M_ACC = 17'h00400, M_DVP = 17'h00200;
  localparam logic [16:0] M_RP  = 17'h00100, M_LQ  = 17'h00080;
  localparam logic [16:0] M_LR  = 17'h00040, M_IR  = 17'h00020;
  localparam logic [16:0] M_RIC = 17'h00010, M_IRM = 17'h00008;
  localparam logic [16:0] M_BSY = 17'h00004, M_DN  = 17'h00002;
  localparam logic [16:0] M_DZ  = 17'h00001;

  logic [16:0] outv;
  assign outv = {LOAD_DIVH, LOAD_DIVL, INV_OP1, OP1_INV_Cin, INV_OP2, OP2_INV_Cin,
                 ACC_LOAD, DIVL_P, RESULT_P, LOAD_QUOT, LOAD_REM, INV_RESULT,
                 RESULT_INV_Cin, INV_REM, Busy, Done, Div_Zero};

  div_sequencer #(.WIDTH(8)) dut (
    .Clock(Clock), .nReset(nReset), .Test(Test), .Start(Start),
    .Op1_Sign(Op1_Sign), .Op2_Sign(Op2_Sign), .Op2_Zero(Op2_Zero),
    .ACC_Cout(ACC_Cout), .LOAD_DIVH(LOAD_DIVH), .LOAD_DIVL(LOAD_DIVL),
    .INV_OP1(INV_OP1), .OP1_INV_Cin(OP1_INV_Cin), .INV_OP2(INV_OP2),
    .OP2_INV_Cin(OP2_INV_Cin), .ACC_LOAD(ACC_LOAD), .DIVL_P(DIVL_P),
    .RESULT_P(RESULT_P), .LOAD_QUOT(LOAD_QUOT), .LOAD_REM(LOAD_REM),
    .INV_RESULT(INV_RESULT), .RESULT_INV_Cin(RESULT_INV_Cin),
    .INV_REM(INV_REM), .Busy(Busy), .Done(Done), .Div_Zero(Div_Zero)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs driven afterwards apply to the new cycle.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Full division from IDLE; checks every cycle through the trailing IDLE.
  task automatic do_div(input logic s1, input logic s2, input logic [7:0] acc,
                        input logic prev_dz, input int freeze_at, input int start_at,
                        input string name);
    logic [16:0] e;
    Start = 1'b1; Op1_Sign = s1; Op2_Sign = s2; Op2_Zero = 1'b0;
    tick();
    Start = 1'b0;
    #1;
    e = M_LDH | M_LDL | M_BSY | (s1 ? (M_IO1 | M_O1C) : '0) |
        (s2 ? (M_IO2 | M_O2C) : '0) | (prev_dz ? M_DZ : '0);
    check({name, "_load"}, outv, e);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == freeze_at) begin
        Test = 1'b1; ACC_Cout = 1'b1;
        #1;
        check($sformatf("%s_frz0", name), outv, M_BSY);
        for (int j = 1; j < 5; j++) begin
          tick();
          check($sformatf("%s_frz%0d", name, j), outv, M_BSY);
        end
        tick();
        Test = 1'b0;
      end
      Start    = (i == start_at);
      ACC_Cout = acc[7-i];
      #1;
      e = M_DVP | M_BSY | (acc[7-i] ? (M_ACC | M_RP) : '0);
      check($sformatf("%s_iter%0d", name, i), outv, e);
    end
    tick();
    Start = 1'b0; ACC_Cout = 1'b0;
    #1;
    e = M_LQ | M_LR | M_BSY | ((s1 ^ s2) ? (M_IR | M_RIC) : '0) | (s1 ? M_IRM : '0);
    check({name, "_fix"}, outv, e);
    tick();
    check({name, "_done"}, outv, M_DN | M_BSY);
    tick();
    check({name, "_idle"}, outv, '0);
  endtask

  initial begin
    nReset = 1'b0; Test = 1'b0; Start = 1'b0; Op1_Sign = 1'b0;
    Op2_Sign = 1'b0; Op2_Zero = 1'b0; ACC_Cout = 1'b0;
    tick();
    tick();
    nReset = 1'b1;
    check("reset", outv, '0);

    // Basic unsigned division with alternating quotient bits.
    do_div(1'b0, 1'b0, 8'b10101010, 1'b0, -1, -1, "plain");
    // Negative dividend: quotient and remainder both negated.
    do_div(1'b1, 1'b0, 8'b11001100, 1'b0, -1, -1, "neg1");
    // Negative divisor: quotient negated, remainder not.
    do_div(1'b0, 1'b1, 8'b00000000, 1'b0, -1, -1, "neg2");

    // Divide by zero: LOAD then straight to DONE, flag sticky into IDLE.
    Start = 1'b1;
    tick();
    Start = 1'b0; Op1_Sign = 1'b0; Op2_Sign = 1'b0; Op2_Zero = 1'b1;
    #1;
    check("dz_load", outv, M_LDH | M_LDL | M_BSY);
    tick();
    Op2_Zero = 1'b0;
    check("dz_done", outv, M_DN | M_BSY | M_DZ);
    tick();
    check("dz_idle", outv, M_DZ);
    // Next division clears the flag after its LOAD.
    do_div(1'b1, 1'b1, 8'hFF, 1'b1, -1, -1, "dzclr");

    // Synchronous reset in the ITER cycle with counter=4, then no Done.
    Start = 1'b1; Op1_Sign = 1'b0; Op2_Sign = 1'b0;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    nReset = 1'b0;
    tick();
    nReset = 1'b1;
    check("rst_mid", outv, '0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("rst_quiet%0d", i), outv, '0);
    end

    // Start pulse during ITER cycle 3 is ignored.
    do_div(1'b0, 1'b0, 8'h0F, 1'b0, -1, 3, "busy_start");
    // Scan freeze at counter=2 for five cycles.
    do_div(1'b0, 1'b0, 8'hA5, 1'b0, 2, -1, "scan");

    // Start held high: Done every 12 cycles with an IDLE gap.
    Start = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      tick();
      check($sformatf("hold_c%0d", c), {16'h0, Done}, {16'h0, (c == 11 || c == 23)});
      if (c == 12) check("hold_gap", {16'h0, Busy}, 17'h0);
      if (c == 23) Start = 1'b0;
    end
    check("hold_end", outv, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
